// File: rtl/ray_scheduler_pkg.sv
// rtl/ray_scheduler_pkg.sv - shared types and constants for the ray magnitude scheduler
package ray_scheduler_pkg;

    // Must track the pipeline depth of the magnitude datapath build
    localparam int RAY_LATENCY_DEFAULT = 6;
    localparam int TAG_ID_WIDTH        = 4;

    typedef struct packed {
        logic                    valid;
        logic [TAG_ID_WIDTH-1:0] id;
    } ray_tag_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/ray_scheduler_rr_arbiter.sv
// rtl/ray_scheduler_rr_arbiter.sv - round-robin one-hot arbiter with registered pointer
module ray_scheduler_rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  eligible,
    output logic [N-1:0]  grant,
    output logic [ID_W-1:0] grant_id,
    output logic          grant_valid
);

    logic [ID_W-1:0] rr_ptr;

    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(idx);
                grant[idx]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (grant_id == ID_W'(N - 1)) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/ray_scheduler.sv
// rtl/ray_scheduler.sv - shares one fixed-latency magnitude datapath among N_REQ requesters
module ray_scheduler
    import ray_scheduler_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int IN_WIDTH    = 8,
    parameter int OUT_WIDTH   = 8,
    parameter int RAY_LATENCY = RAY_LATENCY_DEFAULT,
    parameter int ID_WIDTH    = clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*IN_WIDTH-1:0] req_x,
    input  logic [N_REQ*IN_WIDTH-1:0] req_y,
    output logic [N_REQ-1:0]          req_ready,
    output logic [IN_WIDTH-1:0]       ray_x,
    output logic [IN_WIDTH-1:0]       ray_y,
    input  logic [OUT_WIDTH-1:0]      ray_r,
    output logic [N_REQ-1:0]          res_valid,
    output logic [ID_WIDTH-1:0]       res_id,
    output logic [OUT_WIDTH-1:0]      res_r,
    output logic [N_REQ-1:0]          busy
);

    logic [N_REQ-1:0]    eligible;
    logic [N_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0] grant_id;
    logic                grant_valid;
    logic [N_REQ-1:0]    ret_onehot;

    // Stage 0 lines up with ray_x/ray_y; the last stage lines up with ray_r
    ray_tag_t tags [RAY_LATENCY+1];
    ray_tag_t ret_tag;

    assign eligible   = req_valid & ~busy & {N_REQ{enable}};
    assign req_ready  = grant;
    assign ret_tag    = tags[RAY_LATENCY];
    assign ret_onehot = ret_tag.valid ? (N_REQ'(1) << ret_tag.id) : '0;

    ray_scheduler_rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_WIDTH)
    ) u_arbiter (
        .clk         (clk),
        .reset       (reset),
        .eligible    (eligible),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ray_x     <= '0;
            ray_y     <= '0;
            res_valid <= '0;
            res_id    <= '0;
            res_r     <= '0;
            busy      <= '0;
            for (int i = 0; i <= RAY_LATENCY; i++) tags[i] <= '0;
        end else begin
            if (grant_valid) begin
                ray_x <= req_x[int'(grant_id)*IN_WIDTH +: IN_WIDTH];
                ray_y <= req_y[int'(grant_id)*IN_WIDTH +: IN_WIDTH];
            end else begin
                ray_x <= '0;
                ray_y <= '0;
            end
            tags[0].valid <= grant_valid;
            tags[0].id    <= TAG_ID_WIDTH'(grant_id);
            for (int i = 1; i <= RAY_LATENCY; i++) tags[i] <= tags[i-1];

            // A busy requester is never granted, so set and clear never collide
            busy      <= (busy | grant) & ~ret_onehot;
            res_valid <= ret_onehot;
            if (ret_tag.valid) begin
                res_id <= ID_WIDTH'(ret_tag.id);
                res_r  <= ray_r;
            end
        end
    end

endmodule

// File: tb/tb_ray_scheduler.sv
// tb/tb_ray_scheduler.sv - directed self-checking bench for ray_scheduler
module tb_ray_scheduler;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LAT = 6;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [N-1:0] req_valid;
    logic [N*W-1:0] req_x, req_y;
    logic [N-1:0] req_ready;
    logic [W-1:0] ray_x, ray_y, ray_r;
    logic [N-1:0] res_valid;
    logic [1:0]   res_id;
    logic [W-1:0] res_r;
    logic [N-1:0] busy;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;

    logic [W-1:0] pipe [LAT];

    always #5 clk = ~clk;

    ray_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .ray_x     (ray_x),
        .ray_y     (ray_y),
        .ray_r     (ray_r),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_r     (res_r),
        .busy      (busy)
    );

    function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic [W-1:0] y);
        int xi, yi, v, r;
        xi = int'($signed(x));
        yi = int'($signed(y));
        if (mode == 0) begin
            v = xi * xi + yi * yi;
            r = 0;
            while ((r + 1) * (r + 1) <= v) r++;
        end else begin
            r = (xi < 0 ? -xi : xi) + (yi < 0 ? -yi : yi);
            if (r > 255) r = 255;
        end
        return W'(r);
    endfunction

    // Datapath stand-in: result of operands registered at edge t is valid after edge t+LAT
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= mag(ray_x, ray_y);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign ray_r = pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
    endtask

    task automatic run_single(input string tag, input int i, input logic [W-1:0] x,
                              input logic [W-1:0] y, input logic [W-1:0] exp_r);
        int edges;
        int busy_ok;
        set_req(i, x, y);
        req_valid = N'(1) << i;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(N'(1) << i));
        tick();
        req_valid = '0;
        edges   = 0;
        busy_ok = 1;
        while (res_valid == '0 && edges < 20) begin
            if (busy != (N'(1) << i)) busy_ok = 0;
            tick();
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'(LAT + 1));
        check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
        check({tag, "_res_valid"}, 32'(res_valid), 32'(N'(1) << i));
        check({tag, "_res_id"}, 32'(res_id), 32'(i));
        check({tag, "_res_r"}, 32'(res_r), 32'(exp_r));
        check({tag, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    logic [N-1:0] rdy_log [24];
    logic [N-1:0] rv_log  [24];
    logic [1:0]   id_log  [24];
    logic [W-1:0] r_log   [24];

    task automatic run_log(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            #1;
            rdy_log[c] = req_ready;
            rv_log[c]  = res_valid;
            id_log[c]  = res_id;
            r_log[c]   = res_r;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_grant [12] = '{1, 2, 4, 8, 0, 0, 0, 0, 1, 2, 4, 8};
        int exp_r2    [4]  = '{'h50, 'h66, 'h10, 'h70};
        int seq [$];
        int cnt;

        // Reset state
        do_reset();
        #1;
        check("rst_ray_x", 32'(ray_x), 0);
        check("rst_ray_y", 32'(ray_y), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_id", 32'(res_id), 0);
        check("rst_res_r", 32'(res_r), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready_idle", 32'(req_ready), 0);

        // Single request 3.0, 4.0 -> 5.0
        mode = 0;
        run_single("single", 2, 8'h30, 8'h40, 8'h50);
        tick();
        check("single_pulse_end", 32'(res_valid), 0);
        check("single_id_hold", 32'(res_id), 2);
        check("single_r_hold", 32'(res_r), 32'h50);

        // All four continuously valid from reset
        do_reset();
        set_req(0, 8'h30, 8'h40);
        set_req(1, 8'h50, 8'hC0);
        set_req(2, 8'h00, 8'h10);
        set_req(3, 8'h90, 8'h00);
        req_valid = 4'b1111;
        run_log(12);
        for (int c = 0; c < 12; c++) begin
            check($sformatf("all4_grant_c%0d", c), 32'(rdy_log[c]), 32'(exp_grant[c]));
            check($sformatf("all4_rv_c%0d", c), 32'(rv_log[c]), 32'(c >= 8 ? exp_grant[c] : 0));
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("all4_id_%0d", k), 32'(id_log[8+k]), 32'(k));
            check($sformatf("all4_r_%0d", k), 32'(r_log[8+k]), 32'(exp_r2[k]));
        end

        // Fairness between requesters 1 and 3 with |x|+|y| datapath
        do_reset();
        mode = 1;
        set_req(1, 8'h10, 8'hF0);
        set_req(3, 8'h05, 8'h07);
        req_valid = 4'b1010;
        run_log(20);
        seq.delete();
        for (int c = 0; c < 20; c++) if (rdy_log[c] != '0) seq.push_back(int'(rdy_log[c]));
        check("rr_grant_count", 32'(seq.size()), 6);
        for (int k = 0; k < 6 && k < seq.size(); k++)
            check($sformatf("rr_grant_%0d", k), 32'(seq[k]), (k % 2 == 0) ? 32'h2 : 32'h8);
        check("rr_r_req1", 32'(r_log[8]), 32);
        check("rr_r_req3", 32'(r_log[9]), 12);

        // Back-to-back on requester 0
        do_reset();
        mode = 0;
        set_req(0, 8'h30, 8'h40);
        req_valid = 4'b0001;
        run_log(9);
        cnt = 0;
        for (int c = 1; c < 8; c++) if (rdy_log[c] != '0) cnt++;
        check("b2b_first_grant", 32'(rdy_log[0]), 1);
        check("b2b_no_grant_busy", 32'(cnt), 0);
        check("b2b_result_edge_rv", 32'(rv_log[8]), 1);
        check("b2b_regrant", 32'(rdy_log[8]), 1);

        // enable low with three in flight
        do_reset();
        req_valid = 4'b0111;
        run_log(3);
        check("en_grant0", 32'(rdy_log[0]), 1);
        check("en_grant1", 32'(rdy_log[1]), 2);
        check("en_grant2", 32'(rdy_log[2]), 4);
        enable    = 1'b0;
        req_valid = 4'b1111;
        run_log(12);
        cnt = 0;
        seq.delete();
        for (int c = 0; c < 12; c++) begin
            if (rdy_log[c] != '0) cnt++;
            if (rv_log[c] != '0) seq.push_back(int'(rv_log[c]));
        end
        check("en_no_grants", 32'(cnt), 0);
        check("en_result_count", 32'(seq.size()), 3);
        if (seq.size() == 3) begin
            check("en_result_order0", 32'(seq[0]), 1);
            check("en_result_order2", 32'(seq[2]), 4);
        end
        check("en_busy_drained", 32'(busy), 0);
        enable = 1'b1;
        #1;
        check("en_resume_at_ptr", 32'(req_ready), 8);

        // Reset two cycles after a grant to requester 1
        do_reset();
        set_req(1, 8'h30, 8'h40);
        req_valid = 4'b0010;
        #1;
        check("mrst_grant", 32'(req_ready), 2);
        tick();
        req_valid = '0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_busy", 32'(busy), 0);
        check("mrst_ray_x", 32'(ray_x), 0);
        check("mrst_ray_y", 32'(ray_y), 0);
        run_log(12);
        cnt = 0;
        for (int c = 0; c < 12; c++) if (rv_log[c] != '0) cnt++;
        check("mrst_no_result", 32'(cnt), 0);
        run_single("post_rst", 1, 8'h30, 8'h40, 8'h50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
